// File: rtl/calc_unit.sv
// Multi-cycle signed calculator datapath: single-cycle mul/add/sub, restoring divide/modulo,
// display range check. Define CALC_SAT_EN to clamp out-of-range results instead of flagging err.
module calc_unit #(
    parameter int unsigned W         = 32,
    parameter int          MIN_VAL   = -100000,
    parameter int          MAX_VAL   = 1000000,
    parameter logic [31:0] ERR_CODE  = 32'h00EE0000,
    parameter logic [31:0] NULL_CODE = 32'h00CC0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [2:0]          operator,
    input  logic signed [W-1:0] operand1,
    input  logic signed [W-1:0] operand2,
    output logic                busy,
    output logic                done,
    output logic signed [W-1:0] ans,
    output logic                err
);
    localparam int unsigned W2    = 2 * W;
    localparam int unsigned CW    = 64;
    localparam int unsigned CNT_W = $clog2(W);

    localparam logic [2:0] OP_MUL = 3'd1;
    localparam logic [2:0] OP_DIV = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_SUB = 3'd4;
    localparam logic [2:0] OP_MOD = 3'd5;

    typedef enum logic [1:0] {IDLE, EXEC, DIV, CHECK} state_t;

    state_t                state_q, state_d;
    logic [2:0]            op_q;
    logic signed [W-1:0]   a_q, b_q;
    logic signed [W2-1:0]  res_q;
    logic                  null_q, dz_q, dv_q;
    logic [W-1:0]          quo_q, rem_q, dvs_q;
    logic [CNT_W-1:0]      cnt_q;

    logic                  is_div_c, is_arith_c;
    logic [W-1:0]          mag_a_c, mag_b_c;
    logic [W:0]            rem_sh_c, diff_c;
    logic                  q_bit_c;
    logic [W-1:0]          rem_nx_c;
    logic [W2-1:0]         div_mag_c;
    logic                  div_neg_c;
    logic signed [W2-1:0]  num_c;
    logic signed [CW-1:0]  num_l_c;
    logic signed [W-1:0]   ans_c;
    logic                  err_c;

    assign is_div_c   = (op_q == OP_DIV) || (op_q == OP_MOD);
    assign is_arith_c = (op_q == OP_MUL) || (op_q == OP_ADD) || (op_q == OP_SUB);
    assign mag_a_c    = a_q[W-1] ? W'(-a_q) : W'(a_q);
    assign mag_b_c    = b_q[W-1] ? W'(-b_q) : W'(b_q);

    // One restoring-division step: shift in the next dividend bit, subtract if it fits
    assign rem_sh_c = {rem_q, quo_q[W-1]};
    assign diff_c   = rem_sh_c - {1'b0, dvs_q};
    assign q_bit_c  = ~diff_c[W];
    assign rem_nx_c = q_bit_c ? diff_c[W-1:0] : rem_sh_c[W-1:0];

    // Sign is applied at 2W so that most-negative / -1 stays positive
    assign div_mag_c = (op_q == OP_MOD) ? {{W{1'b0}}, rem_q} : {{W{1'b0}}, quo_q};
    assign div_neg_c = (op_q == OP_MOD) ? a_q[W-1] : (a_q[W-1] ^ b_q[W-1]);
    assign num_c     = dv_q ? (div_neg_c ? $signed(-div_mag_c) : $signed(div_mag_c)) : res_q;
    assign num_l_c   = CW'(num_c);

    always_comb begin
        ans_c = W'(num_c);
        err_c = 1'b0;
        if (null_q) begin
            ans_c = W'(NULL_CODE);
        end else if (dz_q) begin
            ans_c = W'(ERR_CODE);
            err_c = 1'b1;
        end else if (num_l_c >= CW'(MAX_VAL) || num_l_c <= CW'(MIN_VAL)) begin
`ifdef CALC_SAT_EN
            ans_c = (num_l_c >= CW'(MAX_VAL)) ? W'(MAX_VAL - 1) : W'(MIN_VAL + 1);
`else
            ans_c = W'(ERR_CODE);
            err_c = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = EXEC;
            EXEC:    state_d = (is_div_c && b_q != '0) ? DIV : CHECK;
            DIV:     if (cnt_q == '0) state_d = CHECK;
            CHECK:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, single-cycle execute and divider iteration
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            null_q <= 1'b0;
            dz_q   <= 1'b0;
            dv_q   <= 1'b0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    op_q <= operator;
                    a_q  <= operand1;
                    b_q  <= operand2;
                end
                EXEC: begin
                    null_q <= !is_arith_c && !is_div_c;
                    dz_q   <= is_div_c && (b_q == '0);
                    dv_q   <= is_div_c && (b_q != '0);
                    case (op_q)
                        OP_MUL:  res_q <= W2'(a_q) * W2'(b_q);
                        OP_ADD:  res_q <= W2'(a_q) + W2'(b_q);
                        OP_SUB:  res_q <= W2'(a_q) - W2'(b_q);
                        default: res_q <= '0;
                    endcase
                    quo_q <= mag_a_c;
                    rem_q <= '0;
                    dvs_q <= mag_b_c;
                    cnt_q <= CNT_W'(W - 1);
                end
                DIV: begin
                    quo_q <= {quo_q[W-2:0], q_bit_c};
                    rem_q <= rem_nx_c;
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            ans  <= '0;
            err  <= 1'b0;
        end else begin
            busy <= (state_d != IDLE);
            done <= (state_q == CHECK);
            if (state_q == CHECK) begin
                ans <= ans_c;
                err <= err_c;
            end
        end
    end
endmodule
